// File: rtl/cache_fill_if.sv
// Bundle between the cache fill engine (master) and the cache/CPU/memory side (slave).
interface cache_fill_if #(
  parameter int BLOCK_WORDS = 8
);
  localparam int WW = $clog2(BLOCK_WORDS);

  logic          miss_detected;
  logic [15:0]   miss_address;
  logic          fsm_busy;
  logic          memory_req;
  logic [15:0]   memory_address;
  logic          memory_data_valid;
  logic [15:0]   memory_data;
  logic          write_data_array;
  logic [WW-1:0] fill_word;
  logic [15:0]   fill_data;
  logic          write_tag_array;
  logic [15:0]   block_base;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, memory_req, memory_address, write_data_array,
           fill_word, fill_data, write_tag_array, block_base
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, memory_req, memory_address, write_data_array,
           fill_word, fill_data, write_tag_array, block_base
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: issues one read per block word, steers returning words
// into the data array and writes the tag with the final word.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LAT     = 4
) (
  input  logic       clk,
  input  logic       rst,
  cache_fill_if.master bus
);
  localparam int WW = $clog2(BLOCK_WORDS);
  localparam int CW = WW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  localparam logic [CW-1:0] CNT_FULL = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_WORDS - 1);
  localparam logic [15:0]   OFS_MASK = 16'(2 * BLOCK_WORDS - 1);

  if (MEM_LAT < 1 || (1 << WW) != BLOCK_WORDS) begin : g_bad_param
    $error("cache_fill_fsm: BLOCK_WORDS must be a power of 2 and MEM_LAT >= 1");
  end

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0] rcv_cnt_q, rcv_cnt_d;
  logic [15:0]   block_base_q, block_base_d;

  logic issuing;
  logic rcv_fire;
  logic last_word;

  always_comb begin
    issuing   = (state_q == FILL) && (issue_cnt_q < CNT_FULL);
    rcv_fire  = (state_q == FILL) && bus.memory_data_valid;
    last_word = rcv_fire && (rcv_cnt_q == CNT_LAST);

    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    rcv_cnt_d    = rcv_cnt_q;
    block_base_d = block_base_q;

    case (state_q)
      IDLE: begin
        if (bus.miss_detected) begin
          state_d      = FILL;
          block_base_d = bus.miss_address & ~OFS_MASK;
          issue_cnt_d  = '0;
          rcv_cnt_d    = '0;
        end
      end
      FILL: begin
        // issue and receive run independently; only the last received word ends the fill
        if (issuing)   issue_cnt_d = issue_cnt_q + 1'b1;
        if (rcv_fire)  rcv_cnt_d   = rcv_cnt_q + 1'b1;
        if (last_word) state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      issue_cnt_q  <= '0;
      rcv_cnt_q    <= '0;
      block_base_q <= '0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      rcv_cnt_q    <= rcv_cnt_d;
      block_base_q <= block_base_d;
    end
  end

  assign bus.fsm_busy         = (state_q == FILL);
  assign bus.memory_req       = issuing;
  assign bus.memory_address   = issuing ? (block_base_q + (16'(issue_cnt_q) << 1)) : 16'h0000;
  assign bus.write_data_array = rcv_fire;
  assign bus.fill_word        = rcv_cnt_q[WW-1:0];
  // gated so nothing toggles toward the array while idle or in reset
  assign bus.fill_data        = rcv_fire ? bus.memory_data : 16'h0000;
  assign bus.write_tag_array  = last_word;
  assign bus.block_base       = block_base_q;

endmodule
